ntt_sched_ctrl: RTL and testbench

Sequences one full 256-point Kyber NTT or inverse NTT: 7 layers × 128 butterflies, one butterfly per cycle. Drives the 7-bit twiddle ROM address one cycle ahead, so that the ROM's registered 12-bit zeta (low half of its 24-bit output) arrives aligned with the butterfly addresses this block emits. Sits between the top-level polynomial engine (start/done) and the butterfly datapath plus coefficient RAM. The inverse NTT's final scaling by 1441 is out of scope.

---
 rtl/kyber_pkg.sv | 34 +++
 rtl/ntt_addr_gen.sv | 56 +++++
 rtl/ntt_sched_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ntt_sched_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and types for the NTT scheduling logic.
//   N, Q              : ring dimension and modulus
//   NTT_LAYERS        : butterfly layers per 256-point transform
//   NTT_BF_PER_LAYER  : butterflies issued per layer
//   MODE_NTT/INTT     : transform direction encoding on the mode inputs
//   ctrl_state_e      : scheduler FSM states
//   bf_issue_t        : one butterfly as carried through the twiddle alignment pipe
package kyber_pkg;

  localparam int unsigned N                = 256;
  localparam int unsigned Q                = 3329;
  localparam int unsigned NTT_LAYERS       = 7;
  localparam int unsigned NTT_BF_PER_LAYER = 128;

  localparam logic MODE_NTT  = 1'b0;  // Cooley-Tukey, decreasing butterfly span
  localparam logic MODE_INTT = 1'b1;  // Gentleman-Sande, increasing butterfly span

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StGap,
    StFlush,
    StDone
  } ctrl_state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic [2:0] layer;
    logic       last;
  } bf_issue_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Butterfly address generator: maps (mode, layer, butterfly index) to the two
// coefficient indices and the twiddle (zeta) index of that butterfly.
//   mode     : MODE_NTT or MODE_INTT
//   layer    : layer 0..6
//   bf_idx   : butterfly 0..127 within the layer
//   addr_a   : top input index
//   addr_b   : bottom input index (addr_a + span)
//   zeta_idx : twiddle ROM index k
// Purely combinational.
module ntt_addr_gen
  import kyber_pkg::*;
(
  input  logic       mode,
  input  logic [2:0] layer,
  input  logic [6:0] bf_idx,
  output logic [7:0] addr_a,
  output logic [7:0] addr_b,
  output logic [6:0] zeta_idx
);

  logic [2:0] len_log;  // log2 of the butterfly span
  logic [8:0] len;
  logic [6:0] grp;      // butterfly group, one twiddle per group
  logic [6:0] j;        // offset inside the group
  logic [8:0] a_full;
  logic [8:0] b_full;
  logic [7:0] k_full;

  always_comb begin
    if (mode == MODE_INTT) begin
      len_log = layer + 3'd1;
    end else begin
      len_log = 3'd7 - layer;
    end
    len = 9'd1 << len_log;
    grp = bf_idx >> len_log;
    j   = bf_idx & 7'(len - 9'd1);
    // Groups are 2*len apart, so the group base is grp shifted by len_log + 1.
    a_full = ({2'b00, grp} << ({1'b0, len_log} + 4'd1)) + {2'b00, j};
    b_full = a_full + len;
    if (mode == MODE_INTT) begin
      k_full = (8'd128 >> layer) - 8'd1 - {1'b0, grp};
    end else begin
      k_full = (8'd1 << layer) + {1'b0, grp};
    end
  end

  assign addr_a   = a_full[7:0];
  assign addr_b   = b_full[7:0];
  assign zeta_idx = k_full[6:0];

  // Top bits are structurally zero for every legal (layer, bf_idx).
  logic unused_msbs;
  assign unused_msbs = ^{a_full[8], b_full[8], k_full[7]};

endmodule

// File: rtl/ntt_sched_ctrl.sv
// Kyber NTT / inverse-NTT schedule controller.
// Issues 7 layers x 128 butterflies, one per non-stalled cycle, with optional
// bubble cycles between layers. The twiddle ROM address leaves this block
// TW_LAT cycles before the matching butterfly addresses so the ROM's registered
// output lines up with bf_*.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, mode         : begin a transform (IDLE only); direction, latched with start
//   stall               : freezes counters, FSM and alignment pipe
//   busy, done          : transform in flight; one-cycle completion pulse
//   tw_addr             : twiddle ROM address
//   bf_valid            : butterfly strobe, aligned with ROM dout
//   bf_addr_a/bf_addr_b : coefficient indices of the butterfly inputs
//   bf_mode, bf_layer   : latched direction and layer of the butterfly
//   bf_last             : final butterfly of the transform
module ntt_sched_ctrl
  import kyber_pkg::*;
#(
  parameter int unsigned LAYER_GAP = 4,
  parameter int unsigned TW_LAT    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       stall,
  output logic       busy,
  output logic       done,
  output logic [6:0] tw_addr,
  output logic       bf_valid,
  output logic [7:0] bf_addr_a,
  output logic [7:0] bf_addr_b,
  output logic       bf_mode,
  output logic [2:0] bf_layer,
  output logic       bf_last
);

  localparam int unsigned GapW = (LAYER_GAP > 1) ? $clog2(LAYER_GAP) : 1;
  localparam int unsigned FlW  = (TW_LAT > 1) ? $clog2(TW_LAT) : 1;

  localparam logic [2:0]      LastLayer = 3'(NTT_LAYERS - 1);
  localparam logic [6:0]      LastBf    = 7'(NTT_BF_PER_LAYER - 1);
  localparam logic [GapW-1:0] GapLast   = GapW'(LAYER_GAP - 1);
  localparam logic [FlW-1:0]  FlLast    = FlW'(TW_LAT - 1);

  ctrl_state_e     state_q, state_d;
  logic [2:0]      layer_q, layer_d;
  logic [6:0]      bf_q, bf_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [FlW-1:0]  fl_q, fl_d;
  logic            mode_q, mode_d;
  logic [6:0]      tw_q, tw_d;

  logic            issue;
  logic [7:0]      gen_a;
  logic [7:0]      gen_b;
  logic [6:0]      gen_k;
  bf_issue_t       pipe_in;
  bf_issue_t       pipe_q [TW_LAT];

  ntt_addr_gen u_addr_gen (
    .mode     (mode_q),
    .layer    (layer_q),
    .bf_idx   (bf_q),
    .addr_a   (gen_a),
    .addr_b   (gen_b),
    .zeta_idx (gen_k)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Schedule counters, latched mode and last issued twiddle index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      layer_q <= '0;
      bf_q    <= '0;
      gap_q   <= '0;
      fl_q    <= '0;
      mode_q  <= 1'b0;
      tw_q    <= '0;
    end else begin
      layer_q <= layer_d;
      bf_q    <= bf_d;
      gap_q   <= gap_d;
      fl_q    <= fl_d;
      mode_q  <= mode_d;
      tw_q    <= tw_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    bf_d    = bf_q;
    gap_d   = gap_q;
    fl_d    = fl_q;
    mode_d  = mode_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          mode_d  = mode;
          layer_d = '0;
          bf_d    = '0;
        end
      end
      StRun: begin
        if (!stall) begin
          if (bf_q != LastBf) begin
            bf_d = bf_q + 7'd1;
          end else if (layer_q == LastLayer) begin
            state_d = StFlush;
            fl_d    = '0;
          end else if (LAYER_GAP != 0) begin
            state_d = StGap;
            gap_d   = '0;
          end else begin
            layer_d = layer_q + 3'd1;
            bf_d    = '0;
          end
        end
      end
      StGap: begin
        if (!stall) begin
          if (gap_q == GapLast) begin
            state_d = StRun;
            layer_d = layer_q + 3'd1;
            bf_d    = '0;
          end else begin
            gap_d = gap_q + GapW'(1);
          end
        end
      end
      StFlush: begin
        if (!stall) begin
          if (fl_q == FlLast) begin
            state_d = StDone;
          end else begin
            fl_d = fl_q + FlW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs and issue-stage payload.
  always_comb begin
    busy  = (state_q != StIdle);
    done  = (state_q == StDone);
    issue = (state_q == StRun) && !stall;
    // Outside issue cycles the address parks on the last issued index so the
    // ROM output stays matched to the butterfly held on bf_*.
    tw_d    = issue ? gen_k : tw_q;
    pipe_in = '0;
    if (issue) begin
      pipe_in.valid  = 1'b1;
      pipe_in.addr_a = gen_a;
      pipe_in.addr_b = gen_b;
      pipe_in.layer  = layer_q;
      pipe_in.last   = (layer_q == LastLayer) && (bf_q == LastBf);
    end
  end

  // Alignment pipe: TW_LAT stages, frozen together with the schedule.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TW_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (!stall) begin
      pipe_q[0] <= pipe_in;
      for (int unsigned i = 1; i < TW_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tw_addr   = tw_d;
  assign bf_valid  = pipe_q[TW_LAT-1].valid;
  assign bf_addr_a = pipe_q[TW_LAT-1].addr_a;
  assign bf_addr_b = pipe_q[TW_LAT-1].addr_b;
  assign bf_layer  = pipe_q[TW_LAT-1].layer;
  assign bf_last   = pipe_q[TW_LAT-1].last;
  assign bf_mode   = mode_q;

endmodule

// File: tb/tb_ntt_sched_ctrl.sv
// Self-checking bench for ntt_sched_ctrl. Two instances share the clock: unit 0
// with LAYER_GAP = 4, unit 1 with LAYER_GAP = 0, both TW_LAT = 1. The expected
// butterfly stream comes from the reference Kyber ntt/invntt loop nest; a
// one-register ROM model checks that tw_addr leads each butterfly by one cycle.
module tb_ntt_sched_ctrl;

  localparam int NBF = 896;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_s    [2];
  logic       start_s    [2];
  logic       mode_s     [2];
  logic       stall_s    [2];
  logic       busy_s     [2];
  logic       done_s     [2];
  logic [6:0] tw_addr_s  [2];
  logic       bf_valid_s [2];
  logic [7:0] bf_a_s     [2];
  logic [7:0] bf_b_s     [2];
  logic       bf_mode_s  [2];
  logic [2:0] bf_layer_s [2];
  logic       bf_last_s  [2];

  ntt_sched_ctrl #(.LAYER_GAP(4), .TW_LAT(1)) u_dut_gap4 (
    .clk(clk), .rst_n(rst_n_s[0]), .start(start_s[0]), .mode(mode_s[0]),
    .stall(stall_s[0]), .busy(busy_s[0]), .done(done_s[0]), .tw_addr(tw_addr_s[0]),
    .bf_valid(bf_valid_s[0]), .bf_addr_a(bf_a_s[0]), .bf_addr_b(bf_b_s[0]),
    .bf_mode(bf_mode_s[0]), .bf_layer(bf_layer_s[0]), .bf_last(bf_last_s[0])
  );

  ntt_sched_ctrl #(.LAYER_GAP(0), .TW_LAT(1)) u_dut_gap0 (
    .clk(clk), .rst_n(rst_n_s[1]), .start(start_s[1]), .mode(mode_s[1]),
    .stall(stall_s[1]), .busy(busy_s[1]), .done(done_s[1]), .tw_addr(tw_addr_s[1]),
    .bf_valid(bf_valid_s[1]), .bf_addr_a(bf_a_s[1]), .bf_addr_b(bf_b_s[1]),
    .bf_mode(bf_mode_s[1]), .bf_layer(bf_layer_s[1]), .bf_last(bf_last_s[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Edge counter: during the cycle following edge e, cyc == e.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered twiddle ROM model (address only).
  logic [6:0] rom_q [2];
  always @(posedge clk) begin
    rom_q[0] <= tw_addr_s[0];
    rom_q[1] <= tw_addr_s[1];
  end

  // Expected butterfly stream per unit.
  int exp_a [2][NBF];
  int exp_b [2][NBF];
  int exp_k [2][NBF];
  int exp_l [2][NBF];
  bit exp_mode [2];

  // Run tracking, owned by the compare process.
  bit active     [2];
  bit was_active [2];
  bit done_seen  [2];
  bit hold       [2];
  int idx        [2];
  int done_cnt   [2];
  int first_cyc  [2];
  int last_cyc   [2];
  int done_cyc   [2];
  bit touched    [2][7][256];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference Kyber loop nest: ntt counts k up from 1 with shrinking len,
  // invntt counts k down from 127 with growing len.
  task automatic build_model(input int u, input bit m);
    int n;
    int k;
    int layer;
    n     = 0;
    layer = 0;
    if (!m) begin
      k = 1;
      for (int len = 128; len >= 2; len = len / 2) begin
        for (int st = 0; st < 256; st = st + 2 * len) begin
          for (int j = st; j < st + len; j++) begin
            exp_a[u][n] = j; exp_b[u][n] = j + len; exp_k[u][n] = k; exp_l[u][n] = layer;
            n++;
          end
          k++;
        end
        layer++;
      end
    end else begin
      k = 127;
      for (int len = 2; len <= 128; len = len * 2) begin
        for (int st = 0; st < 256; st = st + 2 * len) begin
          for (int j = st; j < st + len; j++) begin
            exp_a[u][n] = j; exp_b[u][n] = j + len; exp_k[u][n] = k; exp_l[u][n] = layer;
            n++;
          end
          k--;
        end
        layer++;
      end
    end
  endtask

  // Compare process: checks every cycle of an active run.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (active[u] && !was_active[u]) begin
        idx[u] = 0; done_cnt[u] = 0; first_cyc[u] = -1; last_cyc[u] = -1;
        done_cyc[u] = -1; hold[u] = 0; done_seen[u] = 0;
        for (int l = 0; l < 7; l++) for (int i = 0; i < 256; i++) touched[u][l][i] = 0;
      end
      was_active[u] = active[u];
      if (active[u]) begin
        if (hold[u]) chk("held_bf_valid", int'(bf_valid_s[u]), 1);
        hold[u] = 0;
        if (done_cnt[u] == 0) chk("busy_in_run", int'(busy_s[u]), 1);
        if (bf_valid_s[u]) begin
          if (idx[u] >= NBF) begin
            chk("extra_bf", idx[u], NBF - 1);
          end else begin
            chk("bf_addr_a", int'(bf_a_s[u]), exp_a[u][idx[u]]);
            chk("bf_addr_b", int'(bf_b_s[u]), exp_b[u][idx[u]]);
            chk("zeta_idx", int'(rom_q[u]), exp_k[u][idx[u]]);
            chk("bf_layer", int'(bf_layer_s[u]), exp_l[u][idx[u]]);
            chk("bf_last", int'(bf_last_s[u]), (idx[u] == NBF - 1) ? 1 : 0);
            chk("bf_mode", int'(bf_mode_s[u]), int'(exp_mode[u]));
          end
          if (first_cyc[u] < 0) first_cyc[u] = cyc + 1;
          last_cyc[u] = cyc + 1;
          if (stall_s[u]) begin
            hold[u] = 1;
          end else begin
            if (idx[u] < NBF) begin
              touched[u][exp_l[u][idx[u]]][bf_a_s[u]] = 1;
              touched[u][exp_l[u][idx[u]]][bf_b_s[u]] = 1;
            end
            idx[u]++;
          end
        end
        if (done_s[u]) begin
          done_cnt[u]++;
          done_cyc[u]  = cyc + 1;
          done_seen[u] = 1;
        end
      end
    end
  end

  task automatic run_xfer(input int u, input bit m, input bit do_stall, input bit do_perturb,
                          input bit lit);
    int tstart;
    int nstall;
    int g;
    int cnt;
    nstall = 0;
    g = (u == 0) ? 4 : 0;
    build_model(u, m);
    exp_mode[u] = m;
    @(posedge clk); #1;
    start_s[u] = 1'b1;
    mode_s[u]  = m;
    @(posedge clk); #1;
    tstart     = cyc;
    start_s[u] = 1'b0;
    active[u]  = 1'b1;
    chk("busy_after_start", int'(busy_s[u]), 1);
    if (lit) begin
      chk("first_tw_addr", int'(tw_addr_s[u]), m ? 127 : 1);
      chk("no_bf_in_first_cycle", int'(bf_valid_s[u]), 0);
    end
    do begin
      stall_s[u] = do_stall && (idx[u] < 700) && ($urandom_range(0, 99) < 30);
      if (stall_s[u]) nstall++;
      if (do_perturb) begin
        mode_s[u]  = 1'($urandom_range(0, 1));
        start_s[u] = (idx[u] >= 300) && (idx[u] < 306);
      end
      @(posedge clk); #1;
    end while (!done_seen[u] && cyc < tstart + 3000);
    stall_s[u] = 1'b0;
    start_s[u] = 1'b0;
    mode_s[u]  = m;
    if (!done_seen[u]) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within 3000 cycles (unit %0d)", u);
    end else begin
      chk("busy_after_done", int'(busy_s[u]), 0);
      chk("done_one_cycle", int'(done_s[u]), 0);
      chk("bf_valid_after_done", int'(bf_valid_s[u]), 0);
    end
    chk("bf_count", idx[u], NBF);
    chk("done_count", done_cnt[u], 1);
    chk("last_bf_cycle", last_cyc[u], tstart + 897 + 6 * g + nstall);
    chk("done_cycle", done_cyc[u], tstart + 898 + 6 * g + nstall);
    if (lit) chk("first_bf_cycle", first_cyc[u], tstart + 2);
    for (int l = 0; l < 7; l++) begin
      cnt = 0;
      for (int i = 0; i < 256; i++) cnt += int'(touched[u][l][i]);
      chk("layer_coverage", cnt, 256);
    end
    active[u] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_abort(input int u);
    int tstart;
    int dcnt;
    build_model(u, 1'b0);
    exp_mode[u] = 1'b0;
    @(posedge clk); #1;
    start_s[u] = 1'b1;
    mode_s[u]  = 1'b0;
    @(posedge clk); #1;
    tstart     = cyc;
    start_s[u] = 1'b0;
    active[u]  = 1'b1;
    do begin
      @(posedge clk); #1;
    end while (idx[u] < 3 * 128 + 50 && cyc < tstart + 3000);
    chk("abort_reached_layer3", int'(bf_layer_s[u]), 3);
    rst_n_s[u] = 1'b0;
    @(posedge clk); #1;
    active[u]  = 1'b0;
    rst_n_s[u] = 1'b1;
    chk("abort_busy", int'(busy_s[u]), 0);
    chk("abort_bf_valid", int'(bf_valid_s[u]), 0);
    chk("abort_tw_addr", int'(tw_addr_s[u]), 0);
    chk("abort_done", int'(done_s[u]), 0);
    chk("abort_bf_addr_a", int'(bf_a_s[u]), 0);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      dcnt += int'(done_s[u]) + int'(busy_s[u]);
    end
    chk("abort_quiet", dcnt, 0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n_s[u] = 1'b0; start_s[u] = 1'b0; mode_s[u] = 1'b0; stall_s[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("reset_busy", int'(busy_s[u]), 0);
      chk("reset_done", int'(done_s[u]), 0);
      chk("reset_tw_addr", int'(tw_addr_s[u]), 0);
      chk("reset_bf_valid", int'(bf_valid_s[u]), 0);
      chk("reset_bf_mode", int'(bf_mode_s[u]), 0);
      rst_n_s[u] = 1'b1;
    end

    // Pin the reference model at the points worked out by hand.
    build_model(0, 1'b0);
    chk("model_ntt_first_k", exp_k[0][0], 1);
    chk("model_ntt_first_b", exp_b[0][0], 128);
    chk("model_ntt_128_k", exp_k[0][128], 2);
    chk("model_ntt_128_b", exp_b[0][128], 64);
    chk("model_ntt_last_k", exp_k[0][NBF-1], 127);
    chk("model_ntt_last_a", exp_a[0][NBF-1], 253);
    build_model(1, 1'b1);
    chk("model_intt_first_k", exp_k[1][0], 127);
    chk("model_intt_first_b", exp_b[1][0], 2);
    chk("model_intt_l6_k", exp_k[1][6*128+77], 1);
    chk("model_intt_last_a", exp_a[1][NBF-1], 127);

    run_xfer(0, 1'b0, 1'b0, 1'b0, 1'b1);  // NTT, gap 4
    run_xfer(1, 1'b1, 1'b0, 1'b0, 1'b1);  // INTT, gap 0
    run_xfer(0, 1'b1, 1'b0, 1'b0, 1'b1);  // INTT, gap 4
    run_xfer(1, 1'b0, 1'b0, 1'b0, 1'b1);  // NTT, gap 0
    run_xfer(0, 1'b0, 1'b1, 1'b0, 1'b0);  // NTT with stalls across RUN and GAP
    run_xfer(1, 1'b1, 1'b1, 1'b0, 1'b0);  // INTT with stalls
    run_abort(0);
    run_xfer(0, 1'b0, 1'b0, 1'b0, 1'b1);  // fresh run after abort
    run_xfer(1, 1'b1, 1'b0, 1'b1, 1'b1);  // restart and mode toggles while busy
    run_xfer(0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
